fft_run_ctrl: RTL and testbench
===============================

Name: fft_run_ctrl

Overview:
Synthesizable run-and-readback controller for top_fft.
- On request, pulses the FFT start and measures FFT latency in cycles, with a timeout.
- After finish, reads all N_SAMPLES result words from the result RAM read port and streams them out over a valid/ready interface.
- Sits between top_fft's result RAM port and a host/UART/DMA consumer; replaces bench-only force/readback for on-FPGA runs.

Parameters:
N_SAMPLES, 8, FFT points; power of 2, >=2; read address width AW = $clog2(N_SAMPLES)
DATA_WIDTH, 16, width of each of re/im; result word = 2*DATA_WIDTH, re in upper half
RD_LATENCY, 2, RAM read latency in cycles from mem_rd_en to mem_rdata valid; 1..4
TIMEOUT_CYCLES, 1000000, RUN cycles before abort; must be < 2^32

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
go  input  1  single-cycle run request; honoured only in IDLE
busy  output  1  high in every state except IDLE
fft_start  output  1  one-cycle start pulse to top_fft
fft_finish  input  1  FFT complete; sampled only in RUN
mem_addr  output  AW  result RAM read address
mem_rd_en  output  1  read issue strobe
mem_rdata  input  2*DATA_WIDTH  read data, valid RD_LATENCY cycles after mem_rd_en
out_valid  output  1  stream data valid
out_ready  input  1  consumer ready
out_data  output  2*DATA_WIDTH  result word
out_index  output  AW  frequency bin index of out_data
out_last  output  1  high with the bin N_SAMPLES-1 word
cycle_count  output  32  measured FFT latency
timeout  output  1  sticky abort flag for the last run
done  output  1  one-cycle pulse at end of run, success or timeout

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; counters 0.
- Reset mid-operation: returns to IDLE at once and flushes all in-flight reads.
- States: IDLE, START, RUN, READ, DONE.
- IDLE: go=1 -> START. cycle_count and timeout keep their last values until go.
- START (1 cycle): fft_start=1; cycle_count<=0; timeout<=0 -> RUN.
- RUN, each cycle:
  - fft_finish=1 -> READ; cycle_count holds.
  - Otherwise, cycle_count==TIMEOUT_CYCLES-1 -> timeout<=1, cycle_count<=TIMEOUT_CYCLES -> DONE, with no readback.
  - Otherwise cycle_count++.
  - Net effect: cycle_count = number of RUN cycles with fft_finish low.
- READ issue side:
  - Output FIFO has depth RD_LATENCY+1.
  - mem_rd_en=1 when issue counter < N_SAMPLES and (FIFO occupancy + reads in flight) < depth.
  - mem_addr = issue counter; counter increments on each issue.
  - In-flight tracking: RD_LATENCY-deep valid/index shift pipeline. Data is pushed into the FIFO with its index when the pipeline output is valid.
  - The credit rule guarantees no overflow, so mem_rdata is never dropped.
- READ stream side:
  - out_valid = FIFO not empty; out_data/out_index/out_last come from the FIFO head.
  - Pop on out_valid & out_ready.
  - out_data/out_index must remain stable while out_valid=1 and out_ready=0.
  - Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
  - With out_ready held at 1, throughput is 1 word/cycle after the initial RD_LATENCY fill.
- Pop of the out_last word -> DONE.
- DONE (1 cycle): done=1 -> IDLE.
- go outside IDLE is ignored. fft_finish outside RUN is ignored.
- fft_finish=1 on the first RUN cycle -> cycle_count=0.

Optional Feature:
BITREV_EN.
- Defined: mem_addr = bit-reverse(issue counter) over AW bits; out_index still carries the natural bin order, i.e. the issue counter. Used for FFT cores that leave results in bit-reversed order.
- Undefined: mem_addr = issue counter, natural order.

Test Plan:
- N_SAMPLES=8, RD_LATENCY=2, RAM model data[i]=i*0x00010001; go; model asserts fft_finish at 20 cycles after the fft_start cycle, out_ready=1 -> cycle_count=19. Then 8 beats, index 0..7, data 0x00000000..0x00070007, out_last only on index 7, done pulse one cycle after that beat, timeout=0.
- Same setup, out_ready toggling 1,0,0,1,... -> same 8 words in order; data held stable during stalls; mem_rd_en never issues beyond 3 outstanding+buffered.
- TIMEOUT_CYCLES=50, fft_finish never asserted -> timeout=1, cycle_count=50, done pulse, zero mem_rd_en and zero out_valid.
- go pulsed during RUN and READ -> ignored; fft_start pulses exactly once per accepted go.
- rst_n dropped mid-READ after 3 beats -> all outputs 0 asynchronously. New go afterwards -> full 8 beats from index 0.
- BITREV_EN defined, N_SAMPLES=8 -> mem_addr sequence 0,4,2,6,1,5,3,7; out_index 0..7; out_data[k] = RAM word at bitrev(k).

Source files
------------

// File: rtl/fft_run_ctrl.sv
// fft_run_ctrl: run-and-readback controller for top_fft.
// Pulses fft_start, measures FFT latency with a timeout, then reads all
// N_SAMPLES result words through a credit-limited read pipeline into a small
// FIFO and streams them out over valid/ready.
// Optional build macro: BITREV_EN (read RAM in bit-reversed address order,
// still reporting natural bin indices on out_index).
module fft_run_ctrl #(
  parameter int          N_SAMPLES      = 8,
  parameter int          DATA_WIDTH     = 16,
  parameter int          RD_LATENCY     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          go,
  output logic                          busy,
  output logic                          fft_start,
  input  logic                          fft_finish,
  output logic [$clog2(N_SAMPLES)-1:0]  mem_addr,
  output logic                          mem_rd_en,
  input  logic [2*DATA_WIDTH-1:0]       mem_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*DATA_WIDTH-1:0]       out_data,
  output logic [$clog2(N_SAMPLES)-1:0]  out_index,
  output logic                          out_last,
  output logic [31:0]                   cycle_count,
  output logic                          timeout,
  output logic                          done
);

  localparam int AW    = $clog2(N_SAMPLES);
  localparam int WW    = 2 * DATA_WIDTH;
  localparam int DEPTH = RD_LATENCY + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int IW    = AW + 1;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TO_FULL = 32'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Control state
  logic [2:0]  state_q, state_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic        timeout_q, timeout_d;
  logic [IW-1:0] issue_q, issue_d;

  // Read pipeline: one valid bit and bin index per cycle of RAM latency
  logic [RD_LATENCY-1:0]         pipe_v_q, pipe_v_d;
  logic [RD_LATENCY-1:0][AW-1:0] pipe_idx_q, pipe_idx_d;

  // Output FIFO
  logic [WW-1:0] fifo_data_mem [DEPTH];
  logic [AW-1:0] fifo_idx_mem  [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic          pop;
  logic [CW:0]   in_flight;
  logic [CW:0]   credit_used;
  logic [AW-1:0] head_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit bookkeeping and issue decision. A pop in the same cycle frees its
  // slot immediately, which is what sustains one word per cycle with a FIFO
  // only RD_LATENCY+1 deep; buffered plus in-flight never exceeds DEPTH.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + (CW + 1)'(pipe_v_q[i]);
    end
    push        = pipe_v_q[RD_LATENCY-1];
    out_valid   = (count_q != '0);
    pop         = out_valid & out_ready;
    head_idx    = fifo_idx_mem[rd_ptr_q];
    credit_used = (CW + 1)'(count_q) + in_flight - (CW + 1)'(pop);
    mem_rd_en   = (state_q == S_READ) && (issue_q < IW'(N_SAMPLES)) &&
                  (credit_used < (CW + 1)'(DEPTH));
  end

  // Head-of-FIFO presentation; masked to zero while nothing is buffered.
  always_comb begin
    out_data  = out_valid ? fifo_data_mem[rd_ptr_q] : '0;
    out_index = out_valid ? head_idx : '0;
    out_last  = out_valid && (head_idx == AW'(N_SAMPLES - 1));
  end

`ifdef BITREV_EN
  function automatic logic [AW-1:0] bit_reverse(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  assign mem_addr = bit_reverse(issue_q[AW-1:0]);
`else
  assign mem_addr = issue_q[AW-1:0];
`endif

  assign busy        = (state_q != S_IDLE);
  assign fft_start   = (state_q == S_START);
  assign done        = (state_q == S_DONE);
  assign cycle_count = cycle_count_q;
  assign timeout     = timeout_q;

  // Run sequencing: start pulse, latency count / timeout, readback, done.
  always_comb begin
    // NOTE: every _d gets its hold value first so no branch leaves it unassigned (no latch).
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    issue_d       = issue_q;
    case (state_q)
      S_IDLE: begin
        if (go) state_d = S_START;
      end
      S_START: begin
        cycle_count_d = '0;
        timeout_d     = 1'b0;
        issue_d       = '0;
        state_d       = S_RUN;
      end
      S_RUN: begin
        if (fft_finish) begin
          state_d = S_READ;
        end else if (cycle_count_q == TO_LAST) begin
          timeout_d     = 1'b1;
          cycle_count_d = TO_FULL;
          state_d       = S_DONE;
        end else begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
      end
      S_READ: begin
        if (mem_rd_en) issue_d = issue_q + IW'(1);
        if (pop && out_last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read-latency shift pipeline and FIFO pointer/occupancy updates.
  always_comb begin
    pipe_v_d      = '0;
    pipe_idx_d    = '0;
    pipe_v_d[0]   = mem_rd_en;
    pipe_idx_d[0] = issue_q[AW-1:0];
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_v_d[i]   = pipe_v_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // State registers; reset also flushes every in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so every flop samples pre-edge values together.
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      issue_q       <= '0;
      pipe_v_q      <= '0;
      pipe_idx_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      issue_q       <= issue_d;
      pipe_v_q      <= pipe_v_d;
      pipe_idx_q    <= pipe_idx_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage: captures RAM data with its bin index as the pipeline drains.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the outputs are masked whenever the FIFO is empty.
    if (push) begin
      fifo_data_mem[wr_ptr_q] <= mem_rdata;
      fifo_idx_mem[wr_ptr_q]  <= pipe_idx_q[RD_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_fft_run_ctrl.sv
// tb_fft_run_ctrl: table-driven and randomized checks of fft_run_ctrl against
// a transaction-level model (expected latency from the timeout rule, expected
// beats and read addresses from RAM contents and bin order).
module tb_fft_run_ctrl;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int WW = 2 * DW;
  localparam int L  = 2;
  localparam int T  = 50;
  localparam int DEPTH = L + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic          busy;
  logic          fft_start;
  logic          fft_finish = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [WW-1:0] mem_rdata;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic [31:0]   cycle_count;
  logic          timeout;
  logic          done;

  fft_run_ctrl #(
    .N_SAMPLES(N), .DATA_WIDTH(DW), .RD_LATENCY(L), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .fft_start(fft_start),
    .fft_finish(fft_finish), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .cycle_count(cycle_count), .timeout(timeout), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- environment models ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WW-1:0] ram [N];
  logic [WW-1:0] rdq [L];
  assign mem_rdata = rdq[L-1];

  // RAM with RD_LATENCY read pipeline; junk when no read was issued.
  always @(posedge clk) begin
    rdq[0] <= mem_rd_en ? ram[mem_addr] : 32'hDEAD_BEEF;
    for (int i = 1; i < L; i++) rdq[i] <= rdq[i-1];
  end

  // FFT model: finish one cycle, finish_delay cycles after the start cycle.
  int finish_delay = 0;
  int since = -1;
  always @(posedge clk) begin
    #1;
    if (!rst_n) since = -1;
    else if (fft_start) since = 0;
    else if (since >= 0) since++;
    fft_finish = (finish_delay != 0) && (since == finish_delay);
  end

  // Consumer: 0 = always ready, 1 = 1,0,0 pattern, 2 = random.
  int ready_mode = 0;
  int ph = 0;
  always @(posedge clk) begin
    #1;
    ph++;
    case (ready_mode)
      1:       out_ready = (ph % 3 == 0);
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: records observations; all comparisons happen in the main thread.
  int start_cnt = 0, done_cnt = 0, valid_cnt = 0, stall_breaks = 0;
  int start_cyc = 0, done_cyc = 0;
  int issued = 0, popped = 0, run_max_outst = 0;
  logic [AW+WW:0] beat_q[$];
  int             beat_cyc_q[$];
  logic [AW-1:0]  addr_q[$];
  logic           stall_prev = 1'b0;
  logic [WW-1:0]  prev_data = '0;
  logic [AW-1:0]  prev_index = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      issued = popped;
    end else begin
      if (fft_start) begin start_cnt++; start_cyc = cyc; run_max_outst = 0; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (mem_rd_en) begin addr_q.push_back(mem_addr); issued++; end
      if (out_valid) valid_cnt++;
      if (stall_prev && (!out_valid || out_data !== prev_data || out_index !== prev_index))
        stall_breaks++;
      if (out_valid && out_ready) begin
        popped++;
        beat_q.push_back({out_index, out_last, out_data});
        beat_cyc_q.push_back(cyc);
      end
      if (issued - popped > run_max_outst) run_max_outst = issued - popped;
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_index = out_index;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [AW-1:0] model_addr(input int k);
`ifdef BITREV_EN
    int r = 0;
    for (int b = 0; b < AW; b++) if (((k >> b) & 1) != 0) r += (1 << (AW - 1 - b));
    return AW'(r);
`else
    return AW'(k);
`endif
  endfunction

  function automatic logic [AW+WW:0] model_beat(input int k);
    return {AW'(k), (k == N - 1), ram[model_addr(k)]};
  endfunction

  task automatic fill_ram(input logic rnd);
    for (int i = 0; i < N; i++) ram[i] = rnd ? WW'($urandom) : WW'(i) * 32'h0001_0001;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ctl"}, {busy, fft_start, mem_rd_en, out_valid, out_last, timeout, done}, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_index"}, out_index, 0);
    check({tag, "_count"}, cycle_count, 0);
  endtask

  // One run: go, wait for done (bounded), compare everything against the model.
  task automatic run_one(input int delay, input int mode, input logic noise,
                         input logic [31:0] exp_count, input logic exp_to, input string tag);
    int b_start = start_cnt, b_done = done_cnt, b_valid = valid_cnt, b_stall = stall_breaks;
    int b_beats = beat_q.size(), b_addr = addr_q.size();
    int n_exp = exp_to ? 0 : N;
    int n_beats, n_addr;
    logic seen = 1'b0;
    finish_delay = delay;
    ready_mode   = mode;
    @(posedge clk); #1; go = 1'b1;
    @(posedge clk); #1; go = 1'b0;
    check({tag, "_start_cycle"}, {busy, fft_start}, 2'b11);
    for (int w = 0; w < 400; w++) begin
      @(posedge clk); #1;
      if (done_cnt != b_done) begin seen = 1'b1; break; end
      go = noise && (cyc % 5 == 2);
    end
    go = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    @(posedge clk); #1;
    check({tag, "_idle_after"}, {busy, done}, 2'b00);
    check({tag, "_start_pulses"}, start_cnt - b_start, 1);
    check({tag, "_done_pulses"}, done_cnt - b_done, 1);
    check({tag, "_cycle_count"}, cycle_count, exp_count);
    check({tag, "_timeout"}, timeout, exp_to);
    n_beats = beat_q.size() - b_beats;
    n_addr  = addr_q.size() - b_addr;
    check({tag, "_n_beats"}, n_beats, n_exp);
    check({tag, "_n_reads"}, n_addr, n_exp);
    for (int k = 0; k < n_exp && k < n_beats; k++)
      check($sformatf("%s_beat%0d", tag, k), beat_q[b_beats + k], model_beat(k));
    for (int k = 0; k < n_exp && k < n_addr; k++)
      check($sformatf("%s_addr%0d", tag, k), addr_q[b_addr + k], model_addr(k));
    if (exp_to) begin
      check({tag, "_valid_cycles"}, valid_cnt - b_valid, 0);
      check({tag, "_done_time"}, done_cyc - start_cyc, T + 1);
    end else if (n_beats == N) begin
      check({tag, "_done_after_last"}, done_cyc - beat_cyc_q[b_beats + N - 1], 1);
      if (mode == 0)
        check({tag, "_throughput"}, beat_cyc_q[b_beats + N - 1] - beat_cyc_q[b_beats], N - 1);
    end
    check({tag, "_stall_stable"}, stall_breaks - b_stall, 0);
    check({tag, "_outstanding_le_depth"}, run_max_outst <= DEPTH, 1);
  endtask

  typedef struct {
    int          delay;
    int          mode;
    logic        noise;
    logic [31:0] exp_count;
    logic        exp_to;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{20, 0, 1'b0, 32'd19, 1'b0};  // basic run, ready held high
    vecs[1] = '{20, 1, 1'b1, 32'd19, 1'b0};  // back-pressure, go noise
    vecs[2] = '{ 1, 0, 1'b0, 32'd0,  1'b0};  // finish on first RUN cycle
    vecs[3] = '{50, 2, 1'b0, 32'd49, 1'b0};  // finish wins on last RUN cycle
    vecs[4] = '{51, 0, 1'b1, 32'd50, 1'b1};  // one cycle too late -> timeout
    vecs[5] = '{ 0, 0, 1'b0, 32'd50, 1'b1};  // finish never arrives
    vecs[6] = '{ 2, 1, 1'b0, 32'd1,  1'b0};

    fill_ram(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      fill_ram(1'b0);
      run_one(vecs[i].delay, vecs[i].mode, vecs[i].noise, vecs[i].exp_count,
              vecs[i].exp_to, $sformatf("vec%0d", i));
    end

    for (int r = 0; r < 6; r++) begin
      int d = $urandom_range(0, 60);
      logic to = (d == 0) || (d > T);
      fill_ram(1'b1);
      run_one(d, 2, 1'(($urandom_range(0, 1))), to ? 32'(T) : 32'(d - 1), to,
              $sformatf("rnd%0d", r));
    end

    // Reset in the middle of readback, then a clean run from bin 0.
    begin
      int b_beats;
      logic got3 = 1'b0;
      fill_ram(1'b0);
      finish_delay = 20;
      ready_mode   = 0;
      b_beats = beat_q.size();
      @(posedge clk); #1; go = 1'b1;
      @(posedge clk); #1; go = 1'b0;
      for (int w = 0; w < 200; w++) begin
        @(posedge clk); #1;
        if (beat_q.size() - b_beats >= 3) begin got3 = 1'b1; break; end
      end
      check("midrst_reached_3_beats", got3, 1);
      #2 rst_n = 1'b0;
      #1;
      check_idle_zero("midrst");
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      run_one(20, 0, 1'b0, 32'd19, 1'b0, "after_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
